// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: default parameters and counter sizing helper.
// Shared by debounce_bit and the input_conditioner top.
`include "input_conditioner_defs.sv"

package input_conditioner_pkg;

  localparam int unsigned IC_WIDTH = `IC_WIDTH_DEF;
  localparam int unsigned IC_SYNC_STAGES = `IC_SYNC_STAGES_DEF;
  localparam int unsigned IC_DEBOUNCE_CYCLES = `IC_DEBOUNCE_CYCLES_DEF;

  // Counter must hold 0..cycles-1; one spare bit keeps cycles=1 legal.
  function automatic int unsigned ic_cnt_w(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// debounce_bit: one-bit synchroniser, stability counter, clean level, edge pulses.
// Ports: clk, rst (sync, active-high), raw_i -> clean_o, rise_o, fall_o.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = IC_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = IC_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = ic_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_i};

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (synced == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Deviation held long enough: commit and pulse once.
      clean_d = synced;
      cnt_d   = '0;
      rise_d  = synced;
      fall_d  = ~synced;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner_defs.sv
// input_conditioner_defs: project-wide defaults for the input conditioner.
// Plain macro values, pulled into the package by the package file.
`ifndef INPUT_CONDITIONER_DEFS_SV
`define INPUT_CONDITIONER_DEFS_SV

`define IC_WIDTH_DEF           3
`define IC_SYNC_STAGES_DEF     2
`define IC_DEBOUNCE_CYCLES_DEF 4

`endif

// File: rtl/input_conditioner.sv
// input_conditioner: WIDTH independent debounced inputs with rise/fall pulses.
// Ports: clk, rst (sync, active-high), raw_in -> clean_out, rise_pulse, fall_pulse.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH           = IC_WIDTH,
  parameter int unsigned SYNC_STAGES     = IC_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = IC_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (raw_in[g]),
      .clean_o(clean_out[g]),
      .rise_o (rise_pulse[g]),
      .fall_o (fall_pulse[g])
    );
  end

endmodule
